alu_arbiter: RTL
================

# alu_arbiter

Shares one combinational 32-bit ALU (`main`: operands A/B, 6-bit funct code, 5-bit shamt) between two requesters. Each requester submits an operation over a valid/ready handshake. The block arbitrates round-robin, registers the winning operands into the ALU, captures the result and returns it on that requester's response channel. Illegal funct codes are rejected without using the ALU. An operation counter supports performance checks.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating completed-operation counter

Ports (`i` = 0, 1):
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req{i}_valid`  in  1  requester i has an operation
- `req{i}_ready`  out  1  operation accepted this cycle
- `req{i}_a`, `req{i}_b`  in  32  operands
- `req{i}_code`  in  6  funct code
- `req{i}_shamt`  in  5  shift amount
- `resp{i}_valid`  out  1  result available for requester i
- `resp{i}_ready`  in  1  requester i consumes the result
- `resp{i}_result`  out  32  ALU result; 0 when error
- `resp{i}_error`  out  1  code was illegal
- `alu_a`, `alu_b`  out  32  to ALU operand inputs (registered)
- `alu_code`  out  6  to ALU funct input (registered)
- `alu_shamt`  out  5  to ALU shamt input (registered)
- `alu_out`  in  32  ALU result, combinational from the `alu_*` outputs
- `busy`  out  1  state != IDLE
- `ops_done`  out  CNT_W  completed operations, saturating

## Operation
- Legal codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x00 sll, 0x02 srl, 0x03 sra. Any other code is illegal.
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:**
  - Arbitrate among asserted `req{i}_valid`.
  - If both are valid, the grant goes to the requester selected by the priority pointer `ptr`.
  - `req{g}_ready` is high combinationally only for the granted requester, and only in IDLE.
  - On accept: latch operands into the `alu_*` registers, record the owner `g`, and set `ptr = ~g`.
  - Legal code → ISSUE. Illegal code → RESP with error=1 and result=0. The `alu_*` registers are still loaded, but the ALU result is ignored.
- **ISSUE:** the `alu_*` registers hold steady. At the end of the cycle, capture `alu_out` into the result register, then → RESP.
- **RESP:**
  - `resp{g}_valid`=1 and the other requester's `resp_valid`=0.
  - When `resp{g}_ready`=1: increment `ops_done` (saturating at all-ones, illegal ops included), then → IDLE.
  - The `ready` of both requesters is 0 throughout.
- `resp{i}_result` and `resp{i}_error` are driven from shared registers. They are meaningful only while `resp{i}_valid` is high.
- `ptr` only changes on a grant. A lone valid requester is granted regardless of `ptr`.

## Timing
- Reset values:
  - State: IDLE. `ptr`: 0 (requester 0 favoured).
  - All `req_ready` and `resp_valid`: 0. Result/error registers: 0.
  - `alu_a`/`alu_b`/`alu_code`/`alu_shamt`: 0. `busy`: 0. `ops_done`: 0.
- Legal operation accepted at edge T: ISSUE during cycle T+1, `resp_valid` from cycle T+2. Illegal: `resp_valid` from cycle T+1.
- `resp_valid` holds until the `resp_ready` edge. The next accept occurs no earlier than 1 cycle after that edge. Minimum spacing is 3 cycles per legal op and 2 per illegal op.
- `req` signals may change while not ready. Inputs are sampled only at the accept edge, so later changes do not affect the operation in flight.
- `resp_ready` asserted while `resp_valid` is low is ignored.
- Reset asserted in any state at edge E: IDLE and all reset values at E. The in-flight operation is dropped with no response and the counter is not incremented.
- `ops_done` at all-ones stays at all-ones on further completions.

## Test plan
- Single requester, `resp0_ready` tied high:
  - a=0xA, b=0x5, codes 0x20/0x22/0x24/0x25 → results 0xF/0x5/0x0/0xF.
  - `resp0_valid` exactly 2 cycles after each accept; `ops_done`=4.
- Shifts, b=0x0000000A, shamt=5:
  - 0x00 → 0x140, 0x02 → 0x0.
  - b=0xFFFFFF00 with 0x03 → 0xFFFFFFF8. `alu_shamt`=5 during ISSUE.
- Both requesters valid continuously, `resp_ready` tied high:
  - Grants alternate 0,1,0,1 starting with 0.
  - Each response appears only on the owner's channel; 3-cycle spacing.
- Illegal code 0x3F from requester 1 → `resp1_valid` 1 cycle after accept, error=1, result=0, no ISSUE cycle. The next request is then served normally.
- Back-pressure: hold `resp0_ready` low for 5 cycles.
  - `resp0_valid`/`resp0_result` stay stable.
  - `req1_ready` stays 0 while `req1_valid` is high.
  - Release → requester 1 is granted 1 cycle later.
- Reset mid-operation during ISSUE → next cycle: `busy`=0, no `resp_valid`, `ops_done` unchanged from reset value 0, `ptr` = 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// One requester channel of the shared-ALU arbiter: an operation request
// (operands, funct code, shift amount) and the matching result response.
// Each direction uses its own valid/ready handshake.
//
// Signals
//   req_valid    requester -> arbiter   operation present
//   req_ready    arbiter   -> requester operation accepted this cycle
//   req_a/req_b  requester -> arbiter   32-bit operands
//   req_code     requester -> arbiter   6-bit funct code
//   req_shamt    requester -> arbiter   5-bit shift amount
//   resp_valid   arbiter   -> requester result available
//   resp_ready   requester -> arbiter   result consumed
//   resp_result  arbiter   -> requester ALU result (0 on error)
//   resp_error   arbiter   -> requester funct code was illegal
//
// Modports
//   master : requester side
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [5:0]  req_code;
   logic [4:0]  req_shamt;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_error;

   modport master (
      output req_valid, req_a, req_b, req_code, req_shamt, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_error
   );

   modport slave (
      input  req_valid, req_a, req_b, req_code, req_shamt, resp_ready,
      output req_ready, resp_valid, resp_result, resp_error
   );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational 32-bit ALU between two requesters.
// Requests are arbitrated round-robin, the winner's operands are registered
// onto the ALU inputs, the ALU result is captured one cycle later and returned
// on the owner's response channel. Illegal funct codes are answered directly
// with error=1 / result=0 without waiting on the ALU. A saturating counter
// tracks completed (consumed) responses.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   req0/req1  slave modports of alu_arbiter_if (request + response channels)
//   alu_a      out  registered operand A to the ALU
//   alu_b      out  registered operand B to the ALU
//   alu_code   out  registered funct code to the ALU
//   alu_shamt  out  registered shift amount to the ALU
//   alu_out    in   ALU result, combinational from the alu_* outputs
//   busy       out  FSM not idle
//   ops_done   out  completed operations, saturating at all-ones
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   alu_arbiter_if.slave     req0,
   alu_arbiter_if.slave     req1,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [5:0]       alu_code,
   output logic [4:0]       alu_shamt,
   input  logic [31:0]      alu_out,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------
   function automatic logic f_is_legal(input logic [5:0] code);
      case (code)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ptr;
   logic                r_owner;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [5:0]          r_alu_code;
   logic [4:0]          r_alu_shamt;
   logic [DATA_W-1:0]   r_result;
   logic                r_error;
   logic [CNT_W-1:0]    r_ops;

   // ---------------------------------------------------------------------------
   // Arbitration: a lone requester wins outright, a tie goes to r_ptr.
   // ---------------------------------------------------------------------------
   logic                w_v0;
   logic                w_v1;
   logic                w_any;
   logic                w_gnt;
   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;
   logic [5:0]          w_sel_code;
   logic [4:0]          w_sel_shamt;
   logic                w_sel_legal;

   assign w_v0        = req0.req_valid;
   assign w_v1        = req1.req_valid;
   assign w_any       = w_v0 | w_v1;
   assign w_gnt       = (w_v0 && w_v1) ? r_ptr : w_v1;
   assign w_sel_a     = w_gnt ? req1.req_a     : req0.req_a;
   assign w_sel_b     = w_gnt ? req1.req_b     : req0.req_b;
   assign w_sel_code  = w_gnt ? req1.req_code  : req0.req_code;
   assign w_sel_shamt = w_gnt ? req1.req_shamt : req0.req_shamt;
   assign w_sel_legal = f_is_legal(w_sel_code);

   // ---------------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // ---------------------------------------------------------------------------
   logic w_accept;
   logic w_capture;
   logic w_done;
   logic w_ready0;
   logic w_ready1;
   logic w_rvalid0;
   logic w_rvalid1;
   logic w_owner_rdy;

   assign w_owner_rdy = r_owner ? req1.resp_ready : req0.resp_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      w_ready0    = 1'b0;
      w_ready1    = 1'b0;
      w_rvalid0   = 1'b0;
      w_rvalid1   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_accept    = 1'b1;
               w_ready0    = ~w_gnt;
               w_ready1    = w_gnt;
               // Illegal codes skip the ALU cycle entirely.
               w_state_nxt = w_sel_legal ? S_ISSUE : S_RESP;
            end
         end
         S_ISSUE: begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_rvalid0 = ~r_owner;
            w_rvalid1 = r_owner;
            if (w_owner_rdy) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 1'b0;
         r_owner <= 1'b0;
         r_ops   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_owner <= w_gnt;
            r_ptr   <= ~w_gnt;
         end
         if (w_done) begin
            r_ops <= f_sat_inc(r_ops);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Operand / result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_code  <= '0;
         r_alu_shamt <= '0;
         r_result    <= '0;
         r_error     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_a     <= w_sel_a;
            r_alu_b     <= w_sel_b;
            r_alu_code  <= w_sel_code;
            r_alu_shamt <= w_sel_shamt;
            // Cleared here so an illegal op reports 0; a legal op overwrites
            // it with the ALU output in the ISSUE cycle.
            r_result    <= '0;
            r_error     <= ~w_sel_legal;
         end else if (w_capture) begin
            r_result    <= alu_out;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign req0.req_ready   = w_ready0;
   assign req1.req_ready   = w_ready1;
   assign req0.resp_valid  = w_rvalid0;
   assign req1.resp_valid  = w_rvalid1;
   assign req0.resp_result = r_result;
   assign req1.resp_result = r_result;
   assign req0.resp_error  = r_error;
   assign req1.resp_error  = r_error;

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_code  = r_alu_code;
   assign alu_shamt = r_alu_shamt;
   assign busy      = (r_state != S_IDLE);
   assign ops_done  = r_ops;

endmodule
